// File: rtl/sub_bytes_engine.sv
// -----------------------------------------------------------------------------
// sub_bytes_engine
// Handshaked, iterative AES byte substitution over a 128-bit state. LANES
// bytes pass through S-boxes per cycle; a block takes 16/LANES cycles.
// Forward (encrypt) or inverse (decrypt) S-box is chosen per block.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input block valid
//   in_ready   engine idle and able to accept a block
//   in_data    input state, byte k = in_data[8k+7:8k]
//   in_inv     0 = forward S-box, 1 = inverse S-box (sampled with in_data)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   substituted state, same byte mapping as in_data
//   busy       engine is not idle
// -----------------------------------------------------------------------------
module sub_bytes_engine #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned NGRP = 16 / LANES;
    localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int unsigned LW   = 8 * LANES;
    localparam logic [GW-1:0] LAST_GRP = GW'(NGRP - 1);

    // Only divisors of 16 give a whole number of groups per block.
    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // 8-bit rotate left.
    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gfinv(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] r;
        s = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    // One inverter shared by both directions: forward = affine(inv(x)),
    // inverse = inv(affine^-1(x)).
    function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
        logic [7:0] y;
        logic [7:0] z;
        y = inv ? (rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05) : x;
        z = gfinv(y);
        return inv ? z
                   : (z ^ rotl8(z, 1) ^ rotl8(z, 2) ^ rotl8(z, 3) ^ rotl8(z, 4) ^ 8'h63);
    endfunction

    state_t          state_q;
    state_t          state_d;
    logic [GW-1:0]   grp_q;
    logic [127:0]    work_q;
    logic [127:0]    result_q;
    logic [127:0]    result_next_c;
    logic [LW-1:0]   sub_c;
    logic            mode_q;
    logic            out_valid_q;

    // The current group always sits in the low bytes of the work register.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign sub_c[8*l +: 8] = sbox(work_q[8*l +: 8], mode_q);
    end

    // Substituted bytes enter at the top and shift down; after NGRP cycles
    // group 0 has reached bytes 0..LANES-1.
    generate
        if (LW == 128) begin : g_full
            assign result_next_c = sub_c;
        end else begin : g_part
            assign result_next_c = {sub_c, result_q[127:LW]};
        end
    endgenerate

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)          state_d = S_BUSY;
            S_BUSY:  if (grp_q == LAST_GRP) state_d = S_DONE;
            S_DONE:  if (out_ready)         state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // State register and datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grp_q       <= '0;
            work_q      <= '0;
            result_q    <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        work_q <= in_data;
                        mode_q <= in_inv;
                        grp_q  <= '0;
                    end
                end
                S_BUSY: begin
                    work_q   <= work_q >> LW;
                    result_q <= result_next_c;
                    grp_q    <= grp_q + GW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = result_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_engine
// Bench for sub_bytes_engine. Five instances (LANES = 4, 1, 2, 8, 16) share
// clock, reset and input data; each has its own handshake signals. Expected
// results are queued when a block is driven and compared when it comes out.
// -----------------------------------------------------------------------------
module tb_sub_bytes_engine;

    localparam int NDUT = 5;

    function automatic int lanes_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            3:       return 8;
            default: return 16;
        endcase
    endfunction

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic              clk;
    logic              rst;
    logic [NDUT-1:0]   iv;
    logic [NDUT-1:0]   ir;
    logic [NDUT-1:0]   ov;
    logic [NDUT-1:0]   ord;
    logic [NDUT-1:0]   bsy;
    logic [127:0]      din;
    logic              dinv;
    logic [127:0]      od [NDUT];

    int                n_cmp;
    int                n_mis;
    logic [127:0]      sb_q [$];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sub_bytes_engine #(.LANES(lanes_of(g))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (din),
            .in_inv    (dinv),
            .out_valid (ov[g]),
            .out_ready (ord[g]),
            .out_data  (od[g]),
            .busy      (bsy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare and count.
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for out_valid on instance d; returns edges seen since accept.
    task automatic wait_out(input int d, output int cyc);
        cyc = 0;
        while (!ov[d] && cyc < 40) begin
            check("busy_while_working", 128'(bsy[d]), 128'd1);
            @(negedge clk);
            cyc++;
        end
        if (!ov[d]) check("out_valid_timeout", 128'd0, 128'd1);
    endtask

    // Send one block to instance d with out_ready high; checks latency,
    // handshake and (when do_chk) the data against the scoreboard.
    task automatic run_block(input int d, input logic [127:0] data, input logic inv,
                             input logic do_chk, input logic [127:0] exp,
                             output logic [127:0] got);
        int cyc;
        logic [127:0] e;
        @(negedge clk);
        check("ready_before_accept", 128'(ir[d]), 128'd1);
        din    = data;
        dinv   = inv;
        iv[d]  = 1'b1;
        ord[d] = 1'b1;
        if (do_chk) sb_q.push_back(exp);
        @(negedge clk);
        iv[d] = 1'b0;
        din   = ~data;           // post-accept input changes must be ignored
        dinv  = ~inv;
        wait_out(d, cyc);
        got = od[d];
        if (ov[d]) begin
            check("latency", 128'(cyc), 128'(16 / lanes_of(d)));
            check("ready_in_done", 128'(ir[d]), 128'd0);
            if (do_chk) begin
                e = sb_q.pop_front();
                check("out_data", got, e);
            end
            @(negedge clk);
            check("valid_cleared", 128'(ov[d]), 128'd0);
            check("data_held_idle", od[d], got);
        end
    endtask

    initial begin
        logic [127:0] r;
        logic [127:0] y;
        logic [127:0] z;
        logic [127:0] e;
        logic         seen;
        int           cyc;

        n_cmp = 0;
        n_mis = 0;
        rst   = 1'b1;
        iv    = '0;
        ord   = '0;
        din   = '0;
        dinv  = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 128'(ov[0]), 128'd0);
        check("rst_out_data", od[0], 128'd0);
        check("rst_busy", 128'(bsy[0]), 128'd0);
        check("rst_in_ready", 128'(ir[0]), 128'd1);
        rst = 1'b0;

        // Asynchronous reset while holding a result in DONE.
        @(negedge clk);
        din    = FIPS_IN;
        dinv   = 1'b0;
        iv[0]  = 1'b1;
        ord[0] = 1'b0;
        @(negedge clk);
        iv[0] = 1'b0;
        wait_out(0, cyc);
        check("pre_rst_data", od[0], FIPS_OUT);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 128'(ov[0]), 128'd0);
        check("async_rst_out_data", od[0], 128'd0);
        check("async_rst_busy", 128'(bsy[0]), 128'd0);
        check("async_rst_in_ready", 128'(ir[0]), 128'd1);
        @(negedge clk);
        rst = 1'b0;

        // LANES=4: FIPS-197 vector, inverse round trip, all-0x63.
        run_block(0, FIPS_IN, 1'b0, 1'b1, FIPS_OUT, y);
        run_block(0, FIPS_OUT, 1'b1, 1'b1, FIPS_IN, y);
        run_block(0, {16{8'h63}}, 1'b1, 1'b1, 128'd0, y);

        // Backpressure: result held while new blocks are offered.
        @(negedge clk);
        din    = 128'd0;
        dinv   = 1'b0;
        iv[0]  = 1'b1;
        ord[0] = 1'b0;
        sb_q.push_back({16{8'h63}});
        @(negedge clk);
        din  = FIPS_OUT;          // next block, offered continuously
        dinv = 1'b1;
        wait_out(0, cyc);
        check("bp_latency", 128'(cyc), 128'd4);
        e = sb_q.pop_front();
        check("bp_first_data", od[0], e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_data_stable", od[0], e);
            check("bp_in_ready_low", 128'(ir[0]), 128'd0);
            check("bp_valid_held", 128'(ov[0]), 128'd1);
        end
        ord[0] = 1'b1;
        sb_q.push_back(FIPS_IN);
        @(negedge clk);
        check("bp_valid_fall", 128'(ov[0]), 128'd0);
        check("bp_in_ready_rise", 128'(ir[0]), 128'd1);
        @(negedge clk);
        iv[0] = 1'b0;
        check("bp_next_accepted", 128'(bsy[0]), 128'd1);
        wait_out(0, cyc);
        check("bp_next_latency", 128'(cyc), 128'd4);
        e = sb_q.pop_front();
        check("bp_next_data", od[0], e);
        @(negedge clk);

        // Mid-operation reset on LANES=1.
        din    = FIPS_IN;
        dinv   = 1'b0;
        iv[1]  = 1'b1;
        ord[1] = 1'b1;
        @(negedge clk);
        iv[1] = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_busy_before_rst", 128'(bsy[1]), 128'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 128'(bsy[1]), 128'd0);
        check("mid_rst_in_ready", 128'(ir[1]), 128'd1);
        check("mid_rst_out_data", od[1], 128'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov[1]) seen = 1'b1;
        end
        check("mid_rst_no_out_valid", 128'(seen), 128'd0);
        run_block(1, FIPS_IN, 1'b0, 1'b1, FIPS_OUT, y);

        // Parameter sweep over LANES = 1, 2, 8, 16.
        for (int d = 1; d < NDUT; d++) begin
            run_block(d, 128'd0, 1'b0, 1'b1, {16{8'h63}}, y);
            run_block(d, {16{8'h53}}, 1'b0, 1'b1, {16{8'hed}}, y);
            run_block(d, {16{8'hed}}, 1'b1, 1'b1, {16{8'h53}}, y);
        end

        // Random round trips across instances of different width.
        for (int i = 0; i < 4; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            run_block(i % NDUT, r, 1'b0, 1'b0, 128'd0, y);
            run_block((i + 2) % NDUT, y, 1'b1, 1'b1, r, z);
        end

        check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Hard stop if the sequence above ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
